// File: rtl/v810_exc_seq.sv
// V810 exception / interrupt / RETI sequencer.
// Saves PC and PSW, records ECR, updates PSW and redirects fetch; RETI restores them.
module v810_exc_seq (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic        EXC_REQ,
  input  logic [15:0] EXC_CODE,
  input  logic [31:0] EXC_PC,
  input  logic        INT_REQ,
  input  logic [3:0]  INT_LEVEL,
  input  logic [31:0] INT_PC,
  input  logic        RETI_REQ,
  output logic        ACK,
  input  logic [31:0] PSW,
  output logic [4:0]  SR_RA,
  input  logic [31:0] SR_RD,
  output logic [4:0]  SR_WA,
  output logic [31:0] SR_WD,
  output logic        SR_WE,
  output logic [31:0] PSW_SET,
  output logic [31:0] PSW_RESET,
  output logic [15:0] ECR_CC,
  output logic        ECR_SET_EICC,
  output logic        ECR_SET_FECC,
  output logic        REDIR_VALID,
  output logic [31:0] REDIR_PC,
  output logic        BUSY,
  output logic        FATAL
);

  localparam logic [4:0] SrEipc  = 5'd0;
  localparam logic [4:0] SrEipsw = 5'd1;
  localparam logic [4:0] SrFepc  = 5'd2;
  localparam logic [4:0] SrFepsw = 5'd3;
  localparam logic [4:0] SrPsw   = 5'd5;

  localparam int unsigned PswId = 12;
  localparam int unsigned PswEp = 14;
  localparam int unsigned PswNp = 15;

  localparam logic [31:0] MaskId = 32'h0000_1000;
  localparam logic [31:0] MaskAe = 32'h0000_2000;
  localparam logic [31:0] MaskEp = 32'h0000_4000;
  localparam logic [31:0] MaskNp = 32'h0000_8000;
  localparam logic [31:0] FeVector = 32'hFFFF_FFD0;

  typedef enum logic [3:0] {
    StIdle, StSavePc, StSavePsw, StUpdPsw, StRedir, StRdPc, StRdPsw, StWrPsw, StHalt
  } state_e;

  typedef enum logic [1:0] {KindEi, KindFe, KindReti} kind_e;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic        is_int_q, is_int_d;
  logic [15:0] code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] psw_q, psw_d;
  logic [31:0] tgt_q, tgt_d;
  logic        fatal_q, fatal_d;

  logic        can_acc, int_ok, acc_exc, acc_reti, acc_int;
  logic [15:0] acc_code;
  logic        fe, reti_np;

  assign can_acc  = (state_q == StIdle) && CE && !fatal_q;
  assign int_ok   = INT_REQ && !PSW[PswId] && !PSW[PswEp] && !PSW[PswNp] &&
                    (INT_LEVEL >= PSW[19:16]);
  assign acc_exc  = can_acc && EXC_REQ;
  assign acc_reti = can_acc && !EXC_REQ && RETI_REQ;
  assign acc_int  = can_acc && !EXC_REQ && !RETI_REQ && int_ok;
  assign ACK      = acc_exc || acc_reti || acc_int;
  assign acc_code = acc_exc ? EXC_CODE : {8'hFE, INT_LEVEL, 4'h0};

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    is_int_d = is_int_q;
    code_d   = code_q;
    pc_d     = pc_q;
    psw_d    = psw_q;
    tgt_d    = tgt_q;
    fatal_d  = fatal_q;
    if (CE) begin
      case (state_q)
        StIdle: begin
          if (acc_exc || acc_int) begin
            code_d   = acc_code;
            pc_d     = acc_exc ? EXC_PC : INT_PC;
            psw_d    = PSW;
            is_int_d = acc_int;
            if (acc_exc && PSW[PswNp]) begin
              fatal_d = 1'b1;
              state_d = StHalt;
            end else begin
              kind_d  = PSW[PswEp] ? KindFe : KindEi;
              tgt_d   = PSW[PswEp] ? FeVector : {16'hFFFF, acc_code[15:4], 4'h0};
              state_d = StSavePc;
            end
          end else if (acc_reti) begin
            kind_d   = KindReti;
            psw_d    = PSW;
            is_int_d = 1'b0;
            state_d  = StRdPc;
          end
        end
        StSavePc:  state_d = StSavePsw;
        StSavePsw: state_d = StUpdPsw;
        StUpdPsw:  state_d = StRedir;
        StRedir:   state_d = StIdle;
        StRdPc: begin
          tgt_d   = {SR_RD[31:1], 1'b0};
          state_d = StRdPsw;
        end
        StRdPsw: begin
          // Snapshot is no longer needed once the save-register source is chosen.
          psw_d   = SR_RD;
          state_d = StWrPsw;
        end
        StWrPsw:   state_d = StRedir;
        StHalt:    state_d = StHalt;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_q  <= StIdle;
      kind_q   <= KindEi;
      is_int_q <= 1'b0;
      code_q   <= '0;
      pc_q     <= '0;
      psw_q    <= '0;
      tgt_q    <= '0;
      fatal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      is_int_q <= is_int_d;
      code_q   <= code_d;
      pc_q     <= pc_d;
      psw_q    <= psw_d;
      tgt_q    <= tgt_d;
      fatal_q  <= fatal_d;
    end
  end

  assign fe      = (kind_q == KindFe);
  assign reti_np = psw_q[PswNp];
  assign BUSY    = (state_q != StIdle);
  assign FATAL   = fatal_q;

  always_comb begin
    SR_RA        = SrPsw;
    SR_WA        = '0;
    SR_WD        = '0;
    SR_WE        = 1'b0;
    PSW_SET      = '0;
    PSW_RESET    = '0;
    ECR_CC       = code_q;
    ECR_SET_EICC = 1'b0;
    ECR_SET_FECC = 1'b0;
    REDIR_VALID  = 1'b0;
    REDIR_PC     = tgt_q;
    case (state_q)
      StSavePc: begin
        SR_WE        = 1'b1;
        SR_WA        = fe ? SrFepc : SrEipc;
        SR_WD        = pc_q;
        ECR_SET_FECC = fe;
        ECR_SET_EICC = !fe;
      end
      StSavePsw: begin
        SR_WE = 1'b1;
        SR_WA = fe ? SrFepsw : SrEipsw;
        SR_WD = psw_q;
      end
      StUpdPsw: begin
        if (fe) begin
          PSW_SET   = MaskNp | MaskId;
          PSW_RESET = MaskAe;
        end else begin
          PSW_SET   = MaskEp | MaskId;
          PSW_RESET = MaskAe;
          if (is_int_q) begin
            // New mask level is one above the accepted level, saturating at 15.
            PSW_RESET[19:16] = 4'hF;
            PSW_SET[19:16]   = (code_q[7:4] == 4'hF) ? 4'hF : code_q[7:4] + 4'h1;
          end
        end
      end
      StRedir:  REDIR_VALID = 1'b1;
      StRdPc:   SR_RA = reti_np ? SrFepc : SrEipc;
      StRdPsw:  SR_RA = reti_np ? SrFepsw : SrEipsw;
      StWrPsw: begin
        SR_WE = 1'b1;
        SR_WA = SrPsw;
        SR_WD = psw_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_v810_exc_seq.sv
// Bench for v810_exc_seq: behavioural sysreg sink, vector table, corner sequences
// and randomized requests checked against a rule-level reference model.
module tb_v810_exc_seq;

  logic        CLK = 1'b0;
  logic        RESn, CE, EXC_REQ, INT_REQ, RETI_REQ;
  logic [15:0] EXC_CODE;
  logic [31:0] EXC_PC, INT_PC;
  logic [3:0]  INT_LEVEL;
  logic [31:0] psw_m, SR_RD;
  logic        ACK, SR_WE, ECR_SET_EICC, ECR_SET_FECC, REDIR_VALID, BUSY, FATAL;
  logic [4:0]  SR_RA, SR_WA;
  logic [31:0] SR_WD, PSW_SET, PSW_RESET, REDIR_PC;
  logic [15:0] ECR_CC;

  v810_exc_seq dut (
    .CLK(CLK), .RESn(RESn), .CE(CE),
    .EXC_REQ(EXC_REQ), .EXC_CODE(EXC_CODE), .EXC_PC(EXC_PC),
    .INT_REQ(INT_REQ), .INT_LEVEL(INT_LEVEL), .INT_PC(INT_PC),
    .RETI_REQ(RETI_REQ), .ACK(ACK), .PSW(psw_m),
    .SR_RA(SR_RA), .SR_RD(SR_RD), .SR_WA(SR_WA), .SR_WD(SR_WD), .SR_WE(SR_WE),
    .PSW_SET(PSW_SET), .PSW_RESET(PSW_RESET), .ECR_CC(ECR_CC),
    .ECR_SET_EICC(ECR_SET_EICC), .ECR_SET_FECC(ECR_SET_FECC),
    .REDIR_VALID(REDIR_VALID), .REDIR_PC(REDIR_PC), .BUSY(BUSY), .FATAL(FATAL)
  );

  always #5 CLK = ~CLK;

  // System-register sink state
  logic [31:0] eipc, eipsw, fepc, fepsw, ecr;

  always_comb begin
    case (SR_RA)
      5'd0:    SR_RD = eipc;
      5'd1:    SR_RD = eipsw;
      5'd2:    SR_RD = fepc;
      5'd3:    SR_RD = fepsw;
      5'd4:    SR_RD = ecr;
      5'd5:    SR_RD = psw_m;
      default: SR_RD = '0;
    endcase
  end

  int n_chk = 0;
  int n_err = 0;
  int n_str, n_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Samples taken at the falling edge
  logic        s_ack, s_rv, s_we, s_seic, s_sfec, s_ce;
  logic [4:0]  s_wa;
  logic [31:0] s_wd, s_pset, s_prst, s_rpc;
  logic [15:0] s_cc;

  task automatic cyc();
    @(negedge CLK);
    s_ack = ACK; s_rv = REDIR_VALID; s_rpc = REDIR_PC; s_we = SR_WE; s_wa = SR_WA;
    s_wd = SR_WD; s_pset = PSW_SET; s_prst = PSW_RESET; s_cc = ECR_CC;
    s_seic = ECR_SET_EICC; s_sfec = ECR_SET_FECC; s_ce = CE;
    if (s_we || s_seic || s_sfec || s_rv || (|s_pset) || (|s_prst)) n_str++;
    if (s_we) n_we++;
    @(posedge CLK);
    #1;
    if (s_ce) begin
      if (s_we) begin
        case (s_wa)
          5'd0: eipc = s_wd;
          5'd1: eipsw = s_wd;
          5'd2: fepc = s_wd;
          5'd3: fepsw = s_wd;
          5'd5: psw_m = s_wd;
          default: ;
        endcase
      end else begin
        psw_m = (psw_m & ~s_prst) | s_pset;
      end
      if (s_seic) ecr[15:0] = s_cc;
      if (s_sfec) ecr[31:16] = s_cc;
    end
  endtask

  task automatic apply_reset();
    RESn = 1'b0; CE = 1'b1; EXC_REQ = 0; RETI_REQ = 0; INT_REQ = 0;
    cyc();
    cyc();
    RESn = 1'b1;
  endtask

  task automatic txn(input bit exc, input bit reti, input bit intr, input logic [15:0] code,
                     input logic [31:0] pc, input logic [3:0] lvl, output bit acked,
                     output bit rv, output int lat, output logic [31:0] rpc);
    int n;
    EXC_REQ = exc; RETI_REQ = reti; INT_REQ = intr;
    EXC_CODE = code; EXC_PC = pc; INT_PC = pc; INT_LEVEL = lvl;
    acked = 0; rv = 0; lat = 0; rpc = '0; n = 0;
    while (!acked && n < 4) begin
      cyc();
      n++;
      acked = s_ack;
    end
    EXC_REQ = 0; RETI_REQ = 0; INT_REQ = 0;
    if (acked) begin
      while (!rv && lat < 12) begin
        cyc();
        lat++;
        if (s_rv) begin
          rv = 1;
          rpc = s_rpc;
        end
      end
    end
  endtask

  // Reference model: architectural effect of one request on the sysreg state
  logic [31:0] m_eipc, m_eipsw, m_fepc, m_fepsw, m_ecr, m_psw, e_rpc;
  bit          e_ack, e_rv, e_fatal;

  task automatic ref_take(input logic [15:0] c, input logic [31:0] pc, input bit is_int,
                          input logic [3:0] lvl);
    logic [31:0] old;
    int newi;
    old = m_psw;
    e_rv = 1;
    if (old[14]) begin
      m_fepc = pc; m_fepsw = old; m_ecr[31:16] = c;
      m_psw = (old | 32'h9000) & ~32'h2000;
      e_rpc = 32'hFFFF_FFD0;
    end else begin
      m_eipc = pc; m_eipsw = old; m_ecr[15:0] = c;
      m_psw = (old | 32'h5000) & ~32'h2000;
      if (is_int) begin
        newi = (int'(lvl) + 1 > 15) ? 15 : int'(lvl) + 1;
        m_psw = (m_psw & ~32'h000F_0000) | (32'(newi) << 16);
      end
      e_rpc = 32'hFFFF_0000 | {16'h0, c & 16'hFFF0};
    end
  endtask

  task automatic ref_step(input bit exc, input bit reti, input bit intr,
                          input logic [15:0] code, input logic [31:0] pc, input logic [3:0] lvl);
    bit np, ep, id;
    np = m_psw[15]; ep = m_psw[14]; id = m_psw[12];
    e_ack = 0; e_rv = 0; e_fatal = 0; e_rpc = '0;
    if (exc) begin
      e_ack = 1;
      if (np) e_fatal = 1;
      else ref_take(code, pc, 0, 4'h0);
    end else if (reti) begin
      e_ack = 1; e_rv = 1;
      if (np) begin
        e_rpc = m_fepc & ~32'h1; m_psw = m_fepsw;
      end else begin
        e_rpc = m_eipc & ~32'h1; m_psw = m_eipsw;
      end
    end else if (intr && !id && !ep && !np && lvl >= m_psw[19:16]) begin
      e_ack = 1;
      ref_take({8'hFE, lvl, 4'h0}, pc, 1, lvl);
    end
  endtask

  typedef struct {
    bit          exc, reti, intr;
    logic [15:0] code;
    logic [31:0] pc;
    logic [3:0]  lvl;
    logic [31:0] psw, eipc, eipsw, fepc, fepsw;
    bit          e_ack, e_fatal;
    logic [31:0] e_psw, e_rpc, e_eipc, e_eipsw, e_fepc, e_fepsw, e_ecr;
  } vec_t;

  vec_t vt[14];

  task automatic check_result(input string tag, input bit ack_x, input bit fatal_x,
                              input bit acked, input bit rv, input int lat,
                              input logic [31:0] rpc, input logic [31:0] rpc_x);
    chk({tag, " ack"}, 32'(acked), 32'(ack_x));
    chk({tag, " fatal"}, 32'(FATAL), 32'(fatal_x));
    chk({tag, " redir"}, 32'(rv), 32'(ack_x && !fatal_x));
    if (ack_x && !fatal_x) begin
      chk({tag, " latency"}, 32'(lat), 32'd4);
      chk({tag, " redir_pc"}, rpc, rpc_x);
    end
    if (!ack_x) chk({tag, " no strobes"}, 32'(n_str), 32'd0);
    if (fatal_x) chk({tag, " no writes"}, 32'(n_we), 32'd0);
  endtask

  initial begin
    bit acked, rv;
    int lat;
    logic [31:0] rpc;
    bit exc, reti, intr;
    logic [15:0] code;
    logic [31:0] pc;
    logic [3:0] lvl;

    vt[0]  = '{1,0,0,16'hFF60,32'h1000,4'd0, 32'h0,     32'h11110000,32'h111,32'h22220000,32'h222,
               1,0, 32'h5000,  32'hFFFFFF60, 32'h1000,32'h0,32'h22220000,32'h222,32'h0000FF60};
    vt[1]  = '{1,0,0,16'hFF90,32'h2468,4'd0, 32'h4000,  32'h11110000,32'h111,32'h22220000,32'h222,
               1,0, 32'hD000,  32'hFFFFFFD0, 32'h11110000,32'h111,32'h2468,32'h4000,32'hFF900000};
    vt[2]  = '{0,0,1,16'h0,32'h3000,4'd3,    32'h40000, 32'h11110000,32'h111,32'h22220000,32'h222,
               0,0, 32'h40000, 32'h0, 32'h11110000,32'h111,32'h22220000,32'h222,32'h0};
    vt[3]  = '{0,0,1,16'h0,32'h3000,4'd5,    32'h40000, 32'h11110000,32'h111,32'h22220000,32'h222,
               1,0, 32'h65000, 32'hFFFFFE50, 32'h3000,32'h40000,32'h22220000,32'h222,32'h0000FE50};
    vt[4]  = '{0,0,1,16'h0,32'h3004,4'd15,   32'hF0000, 32'h11110000,32'h111,32'h22220000,32'h222,
               1,0, 32'hF5000, 32'hFFFFFEF0, 32'h3004,32'hF0000,32'h22220000,32'h222,32'h0000FEF0};
    vt[5]  = '{0,1,0,16'h0,32'h0,4'd0,       32'h0,     32'h2001,32'hA005,32'h22220000,32'h222,
               1,0, 32'hA005,  32'h2000, 32'h2001,32'hA005,32'h22220000,32'h222,32'h0};
    vt[6]  = '{0,1,0,16'h0,32'h0,4'd0,       32'h8000,  32'h2001,32'hA005,32'h4003,32'h1234,
               1,0, 32'h1234,  32'h4002, 32'h2001,32'hA005,32'h4003,32'h1234,32'h0};
    vt[7]  = '{1,1,0,16'hFF00,32'h500,4'd0,  32'h0,     32'h2001,32'hA005,32'h22220000,32'h222,
               1,0, 32'h5000,  32'hFFFFFF00, 32'h500,32'h0,32'h22220000,32'h222,32'h0000FF00};
    vt[8]  = '{1,0,0,16'h1234,32'h600,4'd0,  32'h2000,  32'h11110000,32'h111,32'h22220000,32'h222,
               1,0, 32'h5000,  32'hFFFF1230, 32'h600,32'h2000,32'h22220000,32'h222,32'h00001234};
    vt[9]  = '{0,0,1,16'h0,32'h700,4'd15,    32'h1000,  32'h11110000,32'h111,32'h22220000,32'h222,
               0,0, 32'h1000,  32'h0, 32'h11110000,32'h111,32'h22220000,32'h222,32'h0};
    vt[10] = '{1,0,0,16'hFF60,32'h800,4'd0,  32'h8000,  32'h11110000,32'h111,32'h22220000,32'h222,
               1,1, 32'h8000,  32'h0, 32'h11110000,32'h111,32'h22220000,32'h222,32'h0};
    vt[11] = '{0,0,1,16'h0,32'h700,4'd15,    32'h4000,  32'h11110000,32'h111,32'h22220000,32'h222,
               0,0, 32'h4000,  32'h0, 32'h11110000,32'h111,32'h22220000,32'h222,32'h0};
    vt[12] = '{1,0,1,16'h0040,32'h800,4'd9,  32'h0,     32'h11110000,32'h111,32'h22220000,32'h222,
               1,0, 32'h5000,  32'hFFFF0040, 32'h800,32'h0,32'h22220000,32'h222,32'h00000040};
    vt[13] = '{0,0,1,16'h0,32'h900,4'd7,     32'h70000, 32'h11110000,32'h111,32'h22220000,32'h222,
               1,0, 32'h85000, 32'hFFFFFE70, 32'h900,32'h70000,32'h22220000,32'h222,32'h0000FE70};

    RESn = 1'b0; CE = 1'b1; EXC_REQ = 0; RETI_REQ = 0; INT_REQ = 0;
    EXC_CODE = '0; EXC_PC = '0; INT_PC = '0; INT_LEVEL = '0;
    psw_m = '0; eipc = '0; eipsw = '0; fepc = '0; fepsw = '0; ecr = '0;
    n_str = 0; n_we = 0;
    #1;
    chk("reset ACK", 32'(ACK), 32'd0);
    chk("reset BUSY", 32'(BUSY), 32'd0);
    chk("reset FATAL", 32'(FATAL), 32'd0);
    chk("reset SR_RA", 32'(SR_RA), 32'd5);
    chk("reset REDIR_PC", REDIR_PC, 32'd0);
    chk("reset strobes", {26'd0, SR_WE, ECR_SET_EICC, ECR_SET_FECC, REDIR_VALID,
                          |PSW_SET, |PSW_RESET}, 32'd0);
    apply_reset();

    foreach (vt[i]) begin
      apply_reset();
      psw_m = vt[i].psw; eipc = vt[i].eipc; eipsw = vt[i].eipsw;
      fepc = vt[i].fepc; fepsw = vt[i].fepsw; ecr = '0;
      n_str = 0; n_we = 0;
      txn(vt[i].exc, vt[i].reti, vt[i].intr, vt[i].code, vt[i].pc, vt[i].lvl,
          acked, rv, lat, rpc);
      check_result($sformatf("vec%0d", i), vt[i].e_ack, vt[i].e_fatal, acked, rv, lat,
                   rpc, vt[i].e_rpc);
      chk($sformatf("vec%0d psw", i), psw_m, vt[i].e_psw);
      chk($sformatf("vec%0d eipc", i), eipc, vt[i].e_eipc);
      chk($sformatf("vec%0d eipsw", i), eipsw, vt[i].e_eipsw);
      chk($sformatf("vec%0d fepc", i), fepc, vt[i].e_fepc);
      chk($sformatf("vec%0d fepsw", i), fepsw, vt[i].e_fepsw);
      chk($sformatf("vec%0d ecr", i), ecr, vt[i].e_ecr);
    end

    // Fatal halt is sticky until reset
    apply_reset();
    psw_m = 32'h8000; n_we = 0;
    txn(1, 0, 0, 16'hFF60, 32'h100, 4'd0, acked, rv, lat, rpc);
    chk("fatal ack", 32'(acked), 32'd1);
    chk("fatal FATAL", 32'(FATAL), 32'd1);
    chk("fatal BUSY", 32'(BUSY), 32'd1);
    chk("fatal no SR_WE", 32'(n_we), 32'd0);
    psw_m = 32'h0;
    txn(1, 0, 0, 16'hFF60, 32'h100, 4'd0, acked, rv, lat, rpc);
    chk("fatal later exc ack", 32'(acked), 32'd0);
    txn(0, 1, 0, 16'h0, 32'h0, 4'd0, acked, rv, lat, rpc);
    chk("fatal later reti ack", 32'(acked), 32'd0);
    apply_reset();
    chk("fatal cleared", 32'(FATAL), 32'd0);
    txn(1, 0, 0, 16'hFF60, 32'h100, 4'd0, acked, rv, lat, rpc);
    chk("post-reset ack", 32'(acked), 32'd1);

    // CE held low for three cycles inside SAVE_PSW
    apply_reset();
    psw_m = 32'h0; eipsw = 32'hDEAD;
    EXC_REQ = 1; EXC_CODE = 16'hFF60; EXC_PC = 32'h1000;
    cyc();
    chk("stall ack", 32'(s_ack), 32'd1);
    EXC_REQ = 0;
    lat = 0;
    cyc(); lat++;
    CE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(); lat++;
      chk($sformatf("stall%0d frozen", k), {s_we, 26'd0, s_wa}, {1'b1, 26'd0, 5'd1});
    end
    chk("stall eipsw untouched", eipsw, 32'hDEAD);
    CE = 1'b1;
    rv = 0;
    while (!rv && lat < 20) begin
      cyc(); lat++;
      rv = s_rv;
    end
    chk("stall latency", 32'(lat), 32'd7);
    chk("stall eipsw", eipsw, 32'h0);
    chk("stall psw", psw_m, 32'h5000);

    // Asynchronous reset while in SAVE_PSW
    apply_reset();
    psw_m = 32'h0; eipc = '0; eipsw = 32'hBEEF; ecr = '0;
    EXC_REQ = 1; EXC_CODE = 16'h1111; EXC_PC = 32'h7770;
    cyc();
    EXC_REQ = 0;
    cyc();
    #2 RESn = 1'b0;
    #1;
    chk("async SR_WE", 32'(SR_WE), 32'd0);
    chk("async BUSY", 32'(BUSY), 32'd0);
    chk("async SR_RA", 32'(SR_RA), 32'd5);
    chk("async REDIR_PC", REDIR_PC, 32'd0);
    chk("async ECR_CC", 32'(ECR_CC), 32'd0);
    n_str = 0;
    cyc();
    RESn = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    chk("async no strobes", 32'(n_str), 32'd0);
    chk("async eipc saved", eipc, 32'h7770);
    chk("async eipsw kept", eipsw, 32'hBEEF);
    chk("async psw kept", psw_m, 32'h0);

    // Randomized requests against the reference model
    for (int it = 0; it < 60; it++) begin
      apply_reset();
      eipc = $urandom; eipsw = $urandom; fepc = $urandom; fepsw = $urandom; ecr = $urandom;
      psw_m = $urandom;
      psw_m[12] = ($urandom_range(0, 3) == 0);
      psw_m[14] = ($urandom_range(0, 3) == 0);
      psw_m[15] = ($urandom_range(0, 5) == 0);
      psw_m[19:16] = 4'($urandom_range(0, 15));
      exc = ($urandom_range(0, 3) == 0);
      reti = ($urandom_range(0, 2) == 0);
      intr = ($urandom_range(0, 1) == 1) || (!exc && !reti);
      code = 16'($urandom); pc = $urandom; lvl = 4'($urandom_range(0, 15));
      m_eipc = eipc; m_eipsw = eipsw; m_fepc = fepc; m_fepsw = fepsw;
      m_ecr = ecr; m_psw = psw_m;
      ref_step(exc, reti, intr, code, pc, lvl);
      n_str = 0; n_we = 0;
      txn(exc, reti, intr, code, pc, lvl, acked, rv, lat, rpc);
      check_result($sformatf("rnd%0d", it), e_ack, e_fatal, acked, rv, lat, rpc, e_rpc);
      chk($sformatf("rnd%0d psw", it), psw_m, m_psw);
      chk($sformatf("rnd%0d eipc", it), eipc, m_eipc);
      chk($sformatf("rnd%0d eipsw", it), eipsw, m_eipsw);
      chk($sformatf("rnd%0d fepc", it), fepc, m_fepc);
      chk($sformatf("rnd%0d fepsw", it), fepsw, m_fepsw);
      chk($sformatf("rnd%0d ecr", it), ecr, m_ecr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
